// File: rtl/calc_pkg.sv
// Shared definitions for the calculator Go/Done initiator: opcode encodings,
// opcode width and the sequencer state encoding.
package calc_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD   = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB   = 3'b001;
    localparam logic [OP_W-1:0] OP_AND   = 3'b010;
    localparam logic [OP_W-1:0] OP_XOR   = 3'b011;
    localparam logic [OP_W-1:0] OP_DIV   = 3'b100;
    localparam logic [OP_W-1:0] OP_MUL   = 3'b101;
    localparam logic [OP_W-1:0] OP_PASSA = 3'b110;
    localparam logic [OP_W-1:0] OP_PASSB = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DRAIN = 2'd2,
        S_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/calc_golden.sv
// Combinational reference model of the calculator: expected Out_H/Out_L for an
// operation plus per-field masks selecting which bits take part in the compare.
module calc_golden
    import calc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [OP_W-1:0]  f,
    output logic [WIDTH-1:0] exp_h,
    output logic [WIDTH-1:0] exp_l,
    output logic [WIDTH-1:0] chk_h,
    output logic [WIDTH-1:0] chk_l
);

    logic [2*WIDTH-1:0] prod;

    assign prod = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};

    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        exp_h = '0;
        exp_l = '0;
        chk_h = '0;
        chk_l = '1;
        case (f)
            OP_ADD:   exp_l = x + y;
            OP_SUB:   exp_l = x - y;
            OP_AND:   exp_l = x & y;
            OP_XOR:   exp_l = x ^ y;
            OP_DIV: begin
                // Divide-by-zero: quotient reads as zero, remainder is don't-care.
                if (y != '0) begin
                    exp_l = x / y;
                    exp_h = x % y;
                    chk_h = '1;
                end
            end
            OP_MUL: begin
                {exp_h, exp_l} = prod;
                chk_h          = '1;
            end
            OP_PASSA: exp_l = x;
            OP_PASSB: exp_l = y;
            default:  exp_l = '0;
        endcase
    end

endmodule

// File: rtl/calc_op_sequencer.sv
// Initiator for the calculator Go/Done handshake: takes one command at a time,
// runs it on the calculator, checks the result and returns a tagged response.
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_x,
    input  logic [WIDTH-1:0] cmd_y,
    input  logic [OP_W-1:0]  cmd_f,
    output logic             Go,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [OP_W-1:0]  f,
    input  logic             Done,
    input  logic [WIDTH-1:0] Out_H,
    input  logic [WIDTH-1:0] Out_L,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [OP_W-1:0]  rsp_f,
    output logic [WIDTH-1:0] rsp_out_h,
    output logic [WIDTH-1:0] rsp_out_l,
    output logic             rsp_mismatch,
    output logic             rsp_timeout,
    output logic [CNT_W-1:0] err_count
);

    localparam int            TW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_t           state, state_n;
    logic [TW-1:0]    timer, timer_n;
    logic             go_n;
    logic [WIDTH-1:0] x_n, y_n;
    logic [OP_W-1:0]  f_n;
    logic [WIDTH-1:0] out_h_n, out_l_n;
    logic             mm_n, to_n;
    logic             err_inc;
    logic [CNT_W-1:0] err_n;

    logic [WIDTH-1:0] exp_h, exp_l, chk_h, chk_l;
    logic             mism_now;

    calc_golden #(.WIDTH(WIDTH)) u_golden (
        .x     (x),
        .y     (y),
        .f     (f),
        .exp_h (exp_h),
        .exp_l (exp_l),
        .chk_h (chk_h),
        .chk_l (chk_l)
    );

    // Case inequality so an X/Z in a checked bit counts as a mismatch.
    assign mism_now = ((Out_H & chk_h) !== (exp_h & chk_h)) ||
                      ((Out_L & chk_l) !== (exp_l & chk_l));

    assign cmd_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign rsp_f     = f;

    always_comb begin
        state_n = state;
        timer_n = timer;
        go_n    = Go;
        x_n     = x;
        y_n     = y;
        f_n     = f;
        out_h_n = rsp_out_h;
        out_l_n = rsp_out_l;
        mm_n    = rsp_mismatch;
        to_n    = rsp_timeout;
        err_inc = 1'b0;

        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    x_n     = cmd_x;
                    y_n     = cmd_y;
                    f_n     = cmd_f;
                    go_n    = ~Done;
                    timer_n = '0;
                    out_h_n = '0;
                    out_l_n = '0;
                    mm_n    = 1'b0;
                    to_n    = 1'b0;
                    state_n = S_BUSY;
                end
            end
            S_BUSY: begin
                if (Go && Done) begin
                    out_h_n = Out_H;
                    out_l_n = Out_L;
                    mm_n    = mism_now;
                    go_n    = 1'b0;
                    timer_n = '0;
                    state_n = S_DRAIN;
                end else if (timer == T_LAST) begin
                    go_n    = 1'b0;
                    out_h_n = '0;
                    out_l_n = '0;
                    mm_n    = 1'b0;
                    to_n    = 1'b1;
                    err_inc = 1'b1;
                    state_n = S_RESP;
                end else begin
                    timer_n = timer + 1'b1;
                    // A Done left high by an earlier aborted operation holds off Go.
                    if (!Go && !Done) go_n = 1'b1;
                end
            end
            S_DRAIN: begin
                if (!Done) begin
                    err_inc = rsp_mismatch;
                    state_n = S_RESP;
                end else if (timer == T_LAST) begin
                    out_h_n = '0;
                    out_l_n = '0;
                    mm_n    = 1'b0;
                    to_n    = 1'b1;
                    err_inc = 1'b1;
                    state_n = S_RESP;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        err_n = (err_inc && (err_count != '1)) ? err_count + 1'b1 : err_count;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            timer        <= '0;
            Go           <= 1'b0;
            x            <= '0;
            y            <= '0;
            f            <= '0;
            rsp_out_h    <= '0;
            rsp_out_l    <= '0;
            rsp_mismatch <= 1'b0;
            rsp_timeout  <= 1'b0;
            err_count    <= '0;
        end else begin
            state        <= state_n;
            timer        <= timer_n;
            Go           <= go_n;
            x            <= x_n;
            y            <= y_n;
            f            <= f_n;
            rsp_out_h    <= out_h_n;
            rsp_out_l    <= out_l_n;
            rsp_mismatch <= mm_n;
            rsp_timeout  <= to_n;
            err_count    <= err_n;
        end
    end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Bench for calc_op_sequencer: a calculator responder with programmable Done
// delay and stuck modes, a response scoreboard and a decoupled monitor.
module tb_calc_op_sequencer;
    import calc_pkg::*;

    localparam int WIDTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 16;

    localparam int M_NORMAL = 0;
    localparam int M_NEVER  = 1;
    localparam int M_STUCK  = 2;

    typedef struct packed {
        logic [2:0] f;
        logic [3:0] h;
        logic [3:0] l;
        logic       mm;
        logic       to;
    } exp_t;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] h;
        logic [3:0] l;
    } vec_t;

    // Hand-computed results from a correct calculator (H reads 0 where unused).
    localparam vec_t VECS [9] = '{
        '{4'h9, 4'h8, OP_ADD,   4'h0, 4'h1},
        '{4'h3, 4'h5, OP_SUB,   4'h0, 4'hE},
        '{4'hC, 4'hA, OP_AND,   4'h0, 4'h8},
        '{4'hC, 4'hA, OP_XOR,   4'h0, 4'h6},
        '{4'hD, 4'h4, OP_DIV,   4'h1, 4'h3},
        '{4'hF, 4'hF, OP_MUL,   4'hE, 4'h1},
        '{4'h7, 4'h9, OP_MUL,   4'h3, 4'hF},
        '{4'h7, 4'h2, OP_PASSA, 4'h0, 4'h7},
        '{4'h7, 4'h2, OP_PASSB, 4'h0, 4'h2}
    };

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_x, cmd_y;
    logic [2:0]       cmd_f;
    logic             Go;
    logic [WIDTH-1:0] x, y;
    logic [2:0]       f;
    logic             Done;
    logic [WIDTH-1:0] Out_H, Out_L;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [2:0]       rsp_f;
    logic [WIDTH-1:0] rsp_out_h, rsp_out_l;
    logic             rsp_mismatch, rsp_timeout;
    logic [CNT_W-1:0] err_count;

    int         resp_mode  = M_NORMAL;
    int         resp_delay = 1;
    logic       ovr_en     = 1'b0;
    logic [3:0] ovr_h      = '0;
    logic [3:0] ovr_l      = '0;
    logic       stuck_hold = 1'b0;

    exp_t sb [$];
    int   n_checks = 0;
    int   n_pass   = 0;

    calc_op_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_x        (cmd_x),
        .cmd_y        (cmd_y),
        .cmd_f        (cmd_f),
        .Go           (Go),
        .x            (x),
        .y            (y),
        .f            (f),
        .Done         (Done),
        .Out_H        (Out_H),
        .Out_L        (Out_L),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_f        (rsp_f),
        .rsp_out_h    (rsp_out_h),
        .rsp_out_l    (rsp_out_l),
        .rsp_mismatch (rsp_mismatch),
        .rsp_timeout  (rsp_timeout),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    // Correct calculator behaviour, returned as {Out_H, Out_L}.
    function automatic logic [7:0] calc_model(input logic [3:0] a, input logic [3:0] b,
                                              input logic [2:0] op);
        logic [3:0] s;
        logic [7:0] r;
        r = 8'h00;
        case (op)
            OP_ADD:   begin s = a + b; r = {4'h0, s}; end
            OP_SUB:   begin s = a - b; r = {4'h0, s}; end
            OP_AND:   r = {4'h0, a & b};
            OP_XOR:   r = {4'h0, a ^ b};
            OP_DIV:   r = (b != 4'h0) ? {a % b, a / b} : 8'hF0;
            OP_MUL:   r = {4'h0, a} * {4'h0, b};
            OP_PASSA: r = {4'h0, a};
            default:  r = {4'h0, b};
        endcase
        return r;
    endfunction

    function automatic exp_t mk(input logic [2:0] op, input logic [3:0] h, input logic [3:0] l,
                                input logic mm, input logic to);
        exp_t e;
        e.f = op; e.h = h; e.l = l; e.mm = mm; e.to = to;
        return e;
    endfunction

    // Calculator responder: raises Done resp_delay cycles after seeing Go.
    initial begin
        Done  = 1'b0;
        Out_H = '0;
        Out_L = '0;
        forever begin
            @(posedge clk); #1;
            if (Go && !Done && resp_mode != M_NEVER) begin
                for (int i = 1; i < resp_delay; i++) begin
                    @(posedge clk); #1;
                end
                {Out_H, Out_L} = ovr_en ? {ovr_h, ovr_l} : calc_model(x, y, f);
                Done = 1'b1;
                @(posedge clk); #1;
                while (resp_mode == M_STUCK && stuck_hold) begin
                    @(posedge clk); #1;
                end
                Done = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) $display("FAIL %s: got %0h, required %0h", name, act, req);
        else n_pass++;
    endtask

    task automatic monitor();
        exp_t e;
        exp_t act;
        forever begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                act = mk(rsp_f, rsp_out_h, rsp_out_l, rsp_mismatch, rsp_timeout);
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL rsp_unexpected: got %h, required no response", act);
                end else begin
                    e = sb.pop_front();
                    check("rsp{f,h,l,mm,to}", 32'(act), 32'(e));
                end
            end
        end
    endtask

    // Called and returns #1 after a rising edge; returns just after the accept edge.
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        int n = 0;
        cmd_x = a; cmd_y = b; cmd_f = op; cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drained();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            check("rsp_wait_pending", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        int   cnt;
        exp_t bp;
        rst = 1'b0; cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0; cmd_f = '0; rsp_ready = 1'b1;
        fork
            monitor();
        join_none

        repeat (2) @(posedge clk);
        #1;
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_go", 32'(Go), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_err_count", 32'(err_count), 32'd0);
        check("reset_xyf", 32'({x, y, f}), 32'd0);
        check("reset_rsp_fields", 32'(mk(rsp_f, rsp_out_h, rsp_out_l, rsp_mismatch, rsp_timeout)), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed vectors; the first also checks minimum latency.
        resp_delay = 1;
        for (int i = 0; i < 9; i++) begin
            sb.push_back(mk(VECS[i].op, VECS[i].h, VECS[i].l, 1'b0, 1'b0));
            send(VECS[i].a, VECS[i].b, VECS[i].op);
            if (i == 0) begin
                check("lat_go_rise", 32'(Go), 32'd1);
                check("lat_xyf", 32'({x, y, f}), 32'({4'h9, 4'h8, OP_ADD}));
                @(posedge clk); #1;
                check("lat_go_fall", 32'(Go), 32'd0);
                check("lat_no_rsp_yet", 32'(rsp_valid), 32'd0);
                @(posedge clk); #1;
                check("lat_rsp_valid", 32'(rsp_valid), 32'd1);
            end
            wait_drained();
        end

        // All operand pairs for every opcode, Done delay 1..5.
        for (int op = 0; op < 8; op++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    logic [7:0] r;
                    r = calc_model(4'(a), 4'(b), 3'(op));
                    resp_delay = ((a + b + op) % 5) + 1;
                    sb.push_back(mk(3'(op), r[7:4], r[3:0], 1'b0, 1'b0));
                    send(4'(a), 4'(b), 3'(op));
                    wait_drained();
                end
            end
        end
        check("sweep_err_count", 32'(err_count), 32'd0);

        // Corrupted MUL 7*9 (correct 8'h3F).
        resp_delay = 2; ovr_en = 1'b1; ovr_h = 4'h3; ovr_l = 4'hE;
        sb.push_back(mk(OP_MUL, 4'h3, 4'hE, 1'b1, 1'b0));
        send(4'h7, 4'h9, OP_MUL);
        wait_drained();
        check("mul_fault_err_count", 32'(err_count), 32'd1);

        // Divide by zero: H is don't-care, L must be 0.
        ovr_h = 4'hF; ovr_l = 4'h0;
        sb.push_back(mk(OP_DIV, 4'hF, 4'h0, 1'b0, 1'b0));
        send(4'h9, 4'h0, OP_DIV);
        wait_drained();
        check("div0_ok_err_count", 32'(err_count), 32'd1);
        ovr_l = 4'h1;
        sb.push_back(mk(OP_DIV, 4'hF, 4'h1, 1'b1, 1'b0));
        send(4'h9, 4'h0, OP_DIV);
        wait_drained();
        check("div0_bad_err_count", 32'(err_count), 32'd2);
        ovr_en = 1'b0;

        // Done never asserts: Go is held exactly TIMEOUT cycles.
        resp_mode = M_NEVER;
        sb.push_back(mk(OP_ADD, 4'h0, 4'h0, 1'b0, 1'b1));
        send(4'h3, 4'h4, OP_ADD);
        cnt = 0;
        while (Go && cnt < 200) begin
            cnt++;
            @(posedge clk); #1;
        end
        check("busy_timeout_go_cycles", 32'(cnt), 32'd64);
        wait_drained();
        check("busy_timeout_err_count", 32'(err_count), 32'd3);

        // Done stuck high after the capture: timeout TIMEOUT cycles into DRAIN.
        resp_mode = M_STUCK; stuck_hold = 1'b1; resp_delay = 1;
        sb.push_back(mk(OP_XOR, 4'h0, 4'h0, 1'b0, 1'b1));
        send(4'h5, 4'h3, OP_XOR);
        @(posedge clk); #1;
        check("drain_go_low", 32'(Go), 32'd0);
        cnt = 0;
        while (!rsp_valid && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("drain_timeout_cycles", 32'(cnt), 32'd64);
        wait_drained();
        check("drain_timeout_err_count", 32'(err_count), 32'd4);
        stuck_hold = 1'b0; resp_mode = M_NORMAL;
        repeat (3) @(posedge clk);
        #1;

        // Response backpressure for 10 cycles.
        rsp_ready = 1'b0;
        bp = mk(OP_AND, 4'h0, 4'h2, 1'b0, 1'b0);
        sb.push_back(bp);
        send(4'h6, 4'h3, OP_AND);
        cnt = 0;
        while (!rsp_valid && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_rsp_fields", 32'(mk(rsp_f, rsp_out_h, rsp_out_l, rsp_mismatch, rsp_timeout)), 32'(bp));
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp_go", 32'(Go), 32'd0);
        end
        rsp_ready = 1'b1;
        wait_drained();
        check("bp_err_count", 32'(err_count), 32'd4);

        // Reset while BUSY aborts silently.
        resp_mode = M_NEVER;
        send(4'h1, 4'h2, OP_ADD);
        repeat (5) @(posedge clk);
        #1;
        check("pre_reset_go", 32'(Go), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("mid_reset_go", 32'(Go), 32'd0);
        check("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_reset_err_count", 32'(err_count), 32'd0);
        check("mid_reset_cmd_ready", 32'(cmd_ready), 32'd1);
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (rsp_valid || Go) cnt++;
        end
        check("post_reset_quiet_cycles", 32'(cnt), 32'd0);

        resp_mode = M_NORMAL; resp_delay = 3;
        sb.push_back(mk(OP_ADD, 4'h0, 4'h5, 1'b0, 1'b0));
        send(4'h2, 4'h3, OP_ADD);
        wait_drained();
        check("final_err_count", 32'(err_count), 32'd0);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
